// File: rtl/snn_sched_pkg.sv
// ============================================================================
// snn_sched_pkg : shared types and sizing helpers for the SNN step scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package snn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARMED  = 3'd2,
    S_TICK   = 3'd3,
    S_EVAL   = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  // Bits of configuration carried by one neuron with m input spikes.
  function automatic int cfg_nb(input int m);
    return 6 * m + 6;
  endfunction

  // Host bytes needed to fill the whole layer's bank (last byte may be padded).
  function automatic int nbytes(input int m, input int num_neurons);
    return (num_neurons * cfg_nb(m) + 7) / 8;
  endfunction

  // Field offsets inside one neuron's configuration word, from the LSB.
  localparam int W_OFF = 0;
  function automatic int dv_off(input int m);
    return 2 * m;
  endfunction
  function automatic int de_off(input int m);
    return 5 * m;
  endfunction
  function automatic int th_off(input int m);
    return 6 * m;
  endfunction
  function automatic int dc_off(input int m);
    return 6 * m + 2;
  endfunction
  function automatic int rp_off(input int m);
    return 6 * m + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snn_cfg_bank.sv
// ============================================================================
// snn_cfg_bank : byte-addressed shadow register bank holding the layer config
// Rev 1.0
// ============================================================================
`default_nettype none

module snn_cfg_bank #(
  parameter int CFG_TOT = 36,
  parameter int NBYTES  = 5,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [7:0]         wr_data,
  output logic [CFG_TOT-1:0] cfg
);

  // The final byte stores only the bits that fall inside the bank; padding is dropped.
  for (genvar i = 0; i < NBYTES; i++) begin : g_byte
    localparam int BW = ((CFG_TOT - 8 * i) >= 8) ? 8 : (CFG_TOT - 8 * i);

    logic [BW-1:0] bits;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bits <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        bits <= wr_data[BW-1:0];
      end
    end

    assign cfg[8*i +: BW] = bits;
  end

endmodule

`default_nettype wire

// File: rtl/snn_step_scheduler.sv
// ============================================================================
// snn_step_scheduler : loads layer config, then sequences tick/eval/output steps
// Rev 1.0
// ============================================================================
`default_nettype none

module snn_step_scheduler
  import snn_sched_pkg::*;
#(
  parameter int M           = 2,
  parameter int NUM_NEURONS = 2,
  parameter int EVAL_CYCLES = 2,
  parameter int STEP_W      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_start,
  input  logic                               cfg_valid,
  input  logic [7:0]                         cfg_data,
  output logic                               cfg_ready,
  output logic                               cfg_done,
  input  logic                               in_valid,
  input  logic [M-1:0]                       in_spikes,
  output logic                               in_ready,
  input  logic [NUM_NEURONS-1:0]             neuron_spikes,
  output logic                               out_valid,
  output logic [NUM_NEURONS-1:0]             out_spikes,
  input  logic                               out_ready,
  output logic                               neuron_reset,
  output logic                               neuron_enable,
  output logic                               delay_clk,
  output logic [M-1:0]                       neuron_in_spikes,
  output logic [NUM_NEURONS*cfg_nb(M)-1:0]   neuron_cfg,
  output logic [STEP_W-1:0]                  step_count
);

  localparam int CFG_NB  = cfg_nb(M);
  localparam int CFG_TOT = NUM_NEURONS * CFG_NB;
  localparam int NBYTES  = nbytes(M, NUM_NEURONS);
  localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int EC_W    = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [EC_W-1:0]  EVAL_LOAD = EC_W'(EVAL_CYCLES - 1);

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    wr_idx;
  logic [EC_W-1:0]     eval_cnt;
  logic [M-1:0]        spk_lat;

  logic                cfg_wr;
  logic                restart;
  logic                clr_step;
  logic                accept_in;
  logic                eval_load;
  logic                capture;
  logic                step_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    cfg_ready        = 1'b0;
    cfg_done         = 1'b0;
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    neuron_reset     = 1'b0;
    neuron_enable    = 1'b0;
    delay_clk        = 1'b0;
    neuron_in_spikes = '0;
    cfg_wr           = 1'b0;
    wr_idx           = idx;
    restart          = 1'b0;
    clr_step         = 1'b0;
    accept_in        = 1'b0;
    eval_load        = 1'b0;
    capture          = 1'b0;
    step_inc         = 1'b0;

    case (state)
      S_IDLE: begin
        neuron_reset = 1'b1;
        if (cfg_start) begin
          restart    = 1'b1;
          clr_step   = 1'b1;
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        neuron_reset = 1'b1;
        cfg_ready    = 1'b1;
        // A restart pulse rewinds the pointer; a byte in the same cycle lands at slot 0.
        if (cfg_start) begin
          restart = 1'b1;
          wr_idx  = '0;
        end
        cfg_wr = cfg_valid;
        if (cfg_valid && (wr_idx == LAST_IDX)) begin
          state_next = S_ARMED;
        end
      end

      S_ARMED: begin
        cfg_done = 1'b1;
        in_ready = !cfg_start;
        if (cfg_start) begin
          restart    = 1'b1;
          clr_step   = 1'b1;
          state_next = S_LOAD;
        end else if (in_valid) begin
          accept_in  = 1'b1;
          state_next = S_TICK;
        end
      end

      S_TICK: begin
        delay_clk        = 1'b1;
        neuron_enable    = 1'b1;
        neuron_in_spikes = spk_lat;
        eval_load        = 1'b1;
        state_next       = S_EVAL;
      end

      S_EVAL: begin
        neuron_enable    = 1'b1;
        neuron_in_spikes = spk_lat;
        if (eval_cnt == '0) begin
          capture    = 1'b1;
          state_next = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          step_inc   = 1'b1;
          state_next = S_ARMED;
        end
      end

      default: begin
        neuron_reset = 1'b1;
        state_next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      eval_cnt   <= '0;
      spk_lat    <= '0;
      out_spikes <= '0;
      step_count <= '0;
    end else begin
      if (cfg_wr) begin
        idx <= wr_idx + IDX_W'(1);
      end else if (restart) begin
        idx <= '0;
      end

      if (eval_load) begin
        eval_cnt <= EVAL_LOAD;
      end else if ((state == S_EVAL) && (eval_cnt != '0)) begin
        eval_cnt <= eval_cnt - EC_W'(1);
      end

      if (accept_in) begin
        spk_lat <= in_spikes;
      end

      if (capture) begin
        out_spikes <= neuron_spikes;
      end

      if (clr_step) begin
        step_count <= '0;
      end else if (step_inc) begin
        step_count <= step_count + STEP_W'(1);
      end
    end
  end

  snn_cfg_bank #(
    .CFG_TOT (CFG_TOT),
    .NBYTES  (NBYTES),
    .IDX_W   (IDX_W)
  ) u_cfg_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_wr),
    .wr_idx  (wr_idx),
    .wr_data (cfg_data),
    .cfg     (neuron_cfg)
  );

endmodule

`default_nettype wire

// File: tb/tb_snn_step_scheduler.sv
// ============================================================================
// tb_snn_step_scheduler : randomized self-checking bench with a step-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_snn_step_scheduler;

  localparam int M       = 2;
  localparam int N       = 2;
  localparam int EVAL    = 2;
  localparam int STEP_W  = 4;
  localparam int CFG_TOT = N * (6 * M + 6);
  localparam int NBYTES  = (CFG_TOT + 7) / 8;

  logic                clk;
  logic                rst_n;
  logic                cfg_start;
  logic                cfg_valid;
  logic [7:0]          cfg_data;
  logic                cfg_ready;
  logic                cfg_done;
  logic                in_valid;
  logic [M-1:0]        in_spikes;
  logic                in_ready;
  logic [N-1:0]        neuron_spikes;
  logic                out_valid;
  logic [N-1:0]        out_spikes;
  logic                out_ready;
  logic                neuron_reset;
  logic                neuron_enable;
  logic                delay_clk;
  logic [M-1:0]        neuron_in_spikes;
  logic [CFG_TOT-1:0]  neuron_cfg;
  logic [STEP_W-1:0]   step_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected bank image and completed-step count.
  logic [CFG_TOT-1:0]  model_cfg = '0;
  int                  model_step = 0;

  snn_step_scheduler #(
    .M           (M),
    .NUM_NEURONS (N),
    .EVAL_CYCLES (EVAL),
    .STEP_W      (STEP_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start),
    .cfg_valid        (cfg_valid),
    .cfg_data         (cfg_data),
    .cfg_ready        (cfg_ready),
    .cfg_done         (cfg_done),
    .in_valid         (in_valid),
    .in_spikes        (in_spikes),
    .in_ready         (in_ready),
    .neuron_spikes    (neuron_spikes),
    .out_valid        (out_valid),
    .out_spikes       (out_spikes),
    .out_ready        (out_ready),
    .neuron_reset     (neuron_reset),
    .neuron_enable    (neuron_enable),
    .delay_clk        (delay_clk),
    .neuron_in_spikes (neuron_in_spikes),
    .neuron_cfg       (neuron_cfg),
    .step_count       (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of every control output: {cfg_ready,cfg_done,in_ready,out_valid,neuron_reset,neuron_enable,delay_clk}
  function automatic logic [6:0] ctrl();
    return {cfg_ready, cfg_done, in_ready, out_valid, neuron_reset, neuron_enable, delay_clk};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_data = 0;
    in_valid = 0; in_spikes = 0; neuron_spikes = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl() !== 7'b0000100) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl(), 7'b0000100);
    end
    checks++;
    if ({neuron_cfg, step_count, out_spikes, neuron_in_spikes} !== '0) begin
      errors++; $display("FAIL reset_data: cfg=%h step=%0d out=%b nis=%b expected all zero",
                         neuron_cfg, step_count, out_spikes, neuron_in_spikes);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ctrl() !== 7'b0000100) begin
      errors++; $display("FAIL idle_ctrl: got %b expected %b", ctrl(), 7'b0000100);
    end
  endtask

  task automatic load_cfg(input logic [7:0] b [NBYTES]);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      repeat ($urandom_range(0, 2)) begin
        cfg_valid = 1'b0;
        cfg_data  = 8'($urandom);
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || cfg_done !== 1'b0 || neuron_reset !== 1'b1) begin
          errors++; $display("FAIL load_stall: ready=%b done=%b nrst=%b expected 1 0 1",
                             cfg_ready, cfg_done, neuron_reset);
        end
        tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = b[i];
      tick();
    end
    cfg_valid = 1'b0;
    for (int p = 0; p < CFG_TOT; p++) model_cfg[p] = b[p / 8][p % 8];
    model_step = 0;
    checks++;
    if (cfg_done !== 1'b1 || cfg_ready !== 1'b0 || neuron_reset !== 1'b0) begin
      errors++; $display("FAIL load_done: done=%b ready=%b nrst=%b expected 1 0 0",
                         cfg_done, cfg_ready, neuron_reset);
    end
    checks++;
    if (neuron_cfg !== model_cfg) begin
      errors++; $display("FAIL load_cfg: got %h expected %h", neuron_cfg, model_cfg);
    end
  endtask

  task automatic test_cfg_load();
    logic [7:0] b [NBYTES];
    logic [CFG_TOT-1:0] ref_img;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44; b[4] = 8'h05;
    ref_img = 36'h5_4433_2211;
    load_cfg(b);
    checks++;
    if (neuron_cfg !== ref_img) begin
      errors++; $display("FAIL cfg_known_image: got %h expected %h", neuron_cfg, ref_img);
    end
    tick();
    checks++;
    if (cfg_ready !== 1'b0 || cfg_done !== 1'b1 || step_count !== '0) begin
      errors++; $display("FAIL cfg_armed: ready=%b done=%b step=%0d expected 0 1 0",
                         cfg_ready, cfg_done, step_count);
    end
  endtask

  task automatic test_random_load();
    logic [7:0] b [NBYTES];
    for (int i = 0; i < NBYTES; i++) b[i] = 8'($urandom);
    load_cfg(b);
  endtask

  // One full time step: accept v, check tick/eval timing, capture fin, hold output for `hold` cycles.
  task automatic run_step(input logic [M-1:0] v, input logic [N-1:0] fin, input int hold);
    logic [N-1:0] cap;
    in_valid  = 1'b1;
    in_spikes = v;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL step_in_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    in_spikes = M'($urandom);
    for (int k = 1; k <= EVAL + 1; k++) begin
      neuron_spikes = (k == EVAL + 1) ? fin : N'($urandom);
      #1;
      checks++;
      if (delay_clk !== (k == 1) || neuron_enable !== 1'b1 || neuron_in_spikes !== v ||
          out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL step_eval_c%0d: dclk=%b en=%b nis=%b ov=%b ir=%b expected %b 1 %b 0 0",
                           k, delay_clk, neuron_enable, neuron_in_spikes, out_valid, in_ready,
                           (k == 1), v);
      end
      tick();
    end
    cap = fin;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      neuron_spikes = N'($urandom);
      cfg_start = (h == 1);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_spikes !== cap || in_ready !== 1'b0 ||
          neuron_enable !== 1'b0 || neuron_in_spikes !== '0 || delay_clk !== 1'b0) begin
        errors++; $display("FAIL step_hold_c%0d: ov=%b out=%b ir=%b en=%b nis=%b expected 1 %b 0 0 0",
                           h, out_valid, out_spikes, in_ready, neuron_enable, neuron_in_spikes, cap);
      end
      tick();
    end
    cfg_start = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_spikes !== cap) begin
      errors++; $display("FAIL step_output: ov=%b out=%b expected 1 %b", out_valid, out_spikes, cap);
    end
    tick();
    out_ready  = 1'b0;
    model_step = (model_step + 1) % (1 << STEP_W);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || step_count !== STEP_W'(model_step)) begin
      errors++; $display("FAIL step_release: ov=%b ir=%b step=%0d expected 0 1 %0d",
                         out_valid, in_ready, step_count, model_step);
    end
  endtask

  task automatic test_single_step();
    run_step(2'b11, 2'b10, 0);
  endtask

  task automatic test_back_pressure();
    run_step(M'($urandom), N'($urandom), 5);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      run_step(M'($urandom), N'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_collision();
    cfg_start = 1'b1;
    in_valid  = 1'b1;
    in_spikes = M'($urandom);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL collision_in_ready: got %b expected 0", in_ready);
    end
    tick();
    cfg_start  = 1'b0;
    model_step = 0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (ctrl() !== 7'b1000100 || step_count !== '0) begin
        errors++; $display("FAIL collision_c%0d: ctrl=%b step=%0d expected %b 0",
                           c, ctrl(), step_count, 7'b1000100);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_eval();
    in_valid  = 1'b1;
    in_spikes = M'($urandom);
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_cfg  = '0;
    model_step = 0;
    checks++;
    if (ctrl() !== 7'b0000100 || out_spikes !== '0 || neuron_in_spikes !== '0 ||
        step_count !== '0 || neuron_cfg !== model_cfg) begin
      errors++; $display("FAIL midreset_async: ctrl=%b out=%b nis=%b step=%0d cfg=%h expected %b and zeros",
                         ctrl(), out_spikes, neuron_in_spikes, step_count, neuron_cfg, 7'b0000100);
    end
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ctrl() !== 7'b0000100) begin
        errors++; $display("FAIL midreset_ignore_c%0d: ctrl=%b expected %b", c, ctrl(), 7'b0000100);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    for (int s = 0; s < (1 << STEP_W); s++) begin
      run_step(M'($urandom), N'($urandom), int'($urandom_range(0, 1)));
    end
    checks++;
    if (step_count !== '0) begin
      errors++; $display("FAIL wrap: step_count got %0d expected 0", step_count);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_load();
    test_single_step();
    test_back_pressure();
    test_back_to_back();
    test_collision();
    test_random_load();
    test_back_to_back();
    test_reset_mid_eval();
    test_random_load();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
